// File: rtl/jump_pkg.sv
// Shared definitions for the jump physics stage: FSM encoding, launch-speed limit,
// output ranges and default tick/shift parameters.
package jump_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FLY  = 2'd1,
    ST_DONE = 2'd2,
    ST_REL  = 2'd3
  } state_t;

  localparam int V_MAX        = 127;
  localparam int DIST_MAX     = 253;
  localparam int HEIGHT_MAX   = 254;
  localparam int TICK_DIV_DEF = 50000;
  localparam int H_SHIFT_DEF  = 5;
  localparam int D_SHIFT_DEF  = 7;

  function automatic logic [14:0] sat15(input logic [14:0] x, input int lim);
    return (x > 15'(lim)) ? 15'(lim) : x;
  endfunction

endpackage

// File: rtl/jump_trajectory_tick_gen.sv
// Free-running divider: counts 0..DIV-1 while enabled and asserts tick on the last count.
// Synchronous clear restarts the count so a new jump always gets a full first tick period.
module tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk_machine,
  input  logic rst_machine,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk_machine or posedge rst_machine) begin
    if (rst_machine) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/jump_trajectory.sv
// Ballistic jump integrator: latches launch speed, steps height/distance once per physics tick,
// and pulses o_jump_done on landing; REL holds off relaunch until the FSM drops i_jump_en.
module jump_trajectory
  import jump_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int H_SHIFT  = H_SHIFT_DEF,
  parameter int D_SHIFT  = D_SHIFT_DEF
) (
  input  logic        clk_machine,
  input  logic        rst_machine,
  input  logic        i_jump_en,
  input  logic [10:0] i_v_init,
  output logic        o_jump_done,
  output logic [10:0] o_jump_dist,
  output logic [8:0]  o_jump_height
);

  state_t             state, state_nx;
  logic        [6:0]  v_q, v_in;
  logic signed [7:0]  vy;
  logic signed [14:0] h_acc, h_next;
  logic        [14:0] d_acc;
  logic               tick, landing;
  logic               done_d;
  logic        [8:0]  height_d;
  logic        [10:0] dist_d;

  tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk_machine(clk_machine),
    .rst_machine(rst_machine),
    .clr        (state == ST_IDLE),
    .en         (state == ST_FLY),
    .tick       (tick)
  );

  assign v_in    = (i_v_init > 11'(V_MAX)) ? 7'(V_MAX) : i_v_init[6:0];
  assign h_next  = h_acc + {{7{vy[7]}}, vy};
  // Landing only on the way down, so a zero-height start is not mistaken for touchdown.
  assign landing = vy[7] && (h_next[14] || (h_next == '0));

  always_ff @(posedge clk_machine or posedge rst_machine) begin
    if (rst_machine) state <= ST_IDLE;
    else             state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (i_jump_en) state_nx = (v_in == '0) ? ST_DONE : ST_FLY;
      ST_FLY: begin
        if (tick && landing) state_nx = ST_DONE;
        else if (!i_jump_en) state_nx = ST_IDLE;
      end
      ST_DONE: state_nx = ST_REL;
      ST_REL:  if (!i_jump_en) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    done_d   = (state == ST_DONE);
    height_d = 9'(sat15($unsigned(h_acc) >> H_SHIFT, HEIGHT_MAX));
    dist_d   = 11'(sat15(d_acc >> D_SHIFT, DIST_MAX));
  end

  always_ff @(posedge clk_machine or posedge rst_machine) begin
    if (rst_machine) begin
      v_q   <= '0;
      vy    <= '0;
      h_acc <= '0;
      d_acc <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_jump_en) begin
            v_q   <= v_in;
            vy    <= $signed({1'b0, v_in});
            h_acc <= '0;
            d_acc <= '0;
          end
        end
        ST_FLY: begin
          // A landing tick takes priority over an abort arriving in the same cycle.
          if (tick && landing) begin
            h_acc <= '0;
            d_acc <= d_acc + {8'b0, v_q};
          end else if (!i_jump_en) begin
            h_acc <= '0;
          end else if (tick) begin
            h_acc <= h_next;
            vy    <= vy - 8'sd1;
            d_acc <= d_acc + {8'b0, v_q};
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_machine or posedge rst_machine) begin
    if (rst_machine) begin
      o_jump_done   <= 1'b0;
      o_jump_height <= '0;
      o_jump_dist   <= '0;
    end else begin
      o_jump_done   <= done_d;
      o_jump_height <= height_d;
      o_jump_dist   <= dist_d;
    end
  end

endmodule

// File: tb/tb_jump_trajectory.sv
// Directed bench for jump_trajectory with TICK_DIV = 4; history arrays are indexed by cycle after launch.
module tb_jump_trajectory;

  logic        clk_machine = 1'b0;
  logic        rst_machine = 1'b0;
  logic        i_jump_en   = 1'b0;
  logic [10:0] i_v_init    = '0;
  logic        o_jump_done;
  logic [10:0] o_jump_dist;
  logic [8:0]  o_jump_height;

  int tests = 0;
  int fails = 0;

  int h_hist [0:1199];
  int d_hist [0:1199];
  int dn_hist[0:1199];

  jump_trajectory #(.TICK_DIV(4), .H_SHIFT(5), .D_SHIFT(7)) dut (
    .clk_machine  (clk_machine),
    .rst_machine  (rst_machine),
    .i_jump_en    (i_jump_en),
    .i_v_init     (i_v_init),
    .o_jump_done  (o_jump_done),
    .o_jump_dist  (o_jump_dist),
    .o_jump_height(o_jump_height)
  );

  always #5 clk_machine = ~clk_machine;

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_hist();
    for (int i = 0; i < 1200; i++) begin
      h_hist[i] = -1; d_hist[i] = -1; dn_hist[i] = 0;
    end
  endtask

  // Ends 1 ns after edge 0, the edge that samples the launch request.
  task automatic launch(input int v);
    clear_hist();
    @(negedge clk_machine);
    i_v_init  = 11'(v);
    i_jump_en = 1'b1;
    @(posedge clk_machine);
    #1;
  endtask

  task automatic capture(input int lo, input int hi);
    for (int c = lo; c <= hi; c++) begin
      @(posedge clk_machine);
      #1;
      h_hist[c]  = int'(o_jump_height);
      d_hist[c]  = int'(o_jump_dist);
      dn_hist[c] = int'(o_jump_done);
    end
  endtask

  task automatic drop_en();
    @(negedge clk_machine);
    i_jump_en = 1'b0;
    repeat (3) @(posedge clk_machine);
  endtask

  function automatic int first_done(input int lo, input int hi);
    for (int c = lo; c <= hi; c++) if (dn_hist[c] == 1) return c;
    return -1;
  endfunction

  function automatic int count_done(input int lo, input int hi);
    int n = 0;
    for (int c = lo; c <= hi; c++) n += dn_hist[c];
    return n;
  endfunction

  function automatic int max_h(input int lo, input int hi);
    int m = 0;
    for (int c = lo; c <= hi; c++) if (h_hist[c] > m) m = h_hist[c];
    return m;
  endfunction

  initial begin
    // Reset state
    #2 rst_machine = 1'b1;
    #10;
    check("rst_done",   int'(o_jump_done),   0);
    check("rst_dist",   int'(o_jump_dist),   0);
    check("rst_height", int'(o_jump_height), 0);
    @(negedge clk_machine);
    rst_machine = 1'b0;
    repeat (2) @(posedge clk_machine);

    // Full-speed jump, enable held well past landing; mid-flight speed change is ignored
    launch(127);
    i_v_init = 11'd5;
    capture(1, 1100);
    check("full_done_cycle", first_done(1, 1100), 1021);
    check("full_done_count", count_done(1, 1100), 1);
    check("full_h_508", h_hist[508], 253);
    check("full_h_509", h_hist[509], 254);
    check("full_h_516", h_hist[516], 254);
    check("full_h_517", h_hist[517], 253);
    check("full_h_max", max_h(1, 1100), 254);
    check("full_d_1020", d_hist[1020], 252);
    check("full_d_1021", d_hist[1021], 253);
    check("full_h_1021", h_hist[1021], 0);
    check("full_d_hold_rel", d_hist[1100], 253);
    drop_en();
    #1;
    check("full_d_idle", int'(o_jump_dist), 253);

    // Small jump after release: dist cleared at relaunch
    launch(2);
    capture(1, 40);
    check("small_d_cleared", d_hist[1], 0);
    check("small_done_cycle", first_done(1, 40), 21);
    check("small_done_count", count_done(1, 40), 1);
    check("small_d_end", d_hist[40], 0);
    check("small_h_max", max_h(1, 40), 0);
    drop_en();

    // Clamp: 2000 behaves as 127
    launch(2000);
    capture(1, 1030);
    check("clamp_done_cycle", first_done(1, 1030), 1021);
    check("clamp_d_end", d_hist[1030], 253);
    check("clamp_h_max", max_h(1, 1030), 254);
    drop_en();

    // Zero speed
    launch(0);
    capture(1, 10);
    check("zero_done_cycle", first_done(1, 10), 1);
    check("zero_done_count", count_done(1, 10), 1);
    check("zero_d", d_hist[10], 0);
    check("zero_h_max", max_h(1, 10), 0);
    drop_en();

    // Abort: enable low sampled at edge 200
    launch(127);
    capture(1, 199);
    i_jump_en = 1'b0;
    capture(200, 230);
    check("abort_h_199", h_hist[199], 157);
    check("abort_d_199", d_hist[199], 48);
    check("abort_h_201", h_hist[201], 0);
    check("abort_d_hold", d_hist[230], 48);
    check("abort_no_done", count_done(1, 230), 0);

    // Asynchronous reset mid-flight
    launch(127);
    capture(1, 299);
    check("rstmid_h_299", h_hist[299], 209);
    #2 rst_machine = 1'b1;
    #1;
    check("rstmid_height", int'(o_jump_height), 0);
    check("rstmid_dist",   int'(o_jump_dist),   0);
    check("rstmid_done",   int'(o_jump_done),   0);
    @(negedge clk_machine);
    i_jump_en   = 1'b0;
    rst_machine = 1'b0;
    repeat (3) @(posedge clk_machine);
    launch(127);
    capture(1, 1030);
    check("post_rst_done_cycle", first_done(1, 1030), 1021);
    check("post_rst_done_count", count_done(1, 1030), 1);
    check("post_rst_d_end", d_hist[1030], 253);
    drop_en();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
